// File: rtl/tx_huge_pages_ctrl_pkg.sv
// Shared constants for the TX huge-page controller: TLP fmt/type codes,
// register-map offsets, one-hot FSM encodings and small data helpers.
package tx_huge_pages_ctrl_pkg;

    localparam logic [6:0] FMT_MEM_WR32 = 7'b10_00000;
    localparam logic [6:0] FMT_MEM_WR64 = 7'b11_00000;

    // Offsets relative to REG_BASE, in DWs
    localparam logic [5:0] OFS_UNLOCK = 6'd8;
    localparam logic [5:0] OFS_COMPL  = 6'd12;
    localparam logic [5:0] OFS_SPAN   = 6'd16;

    localparam logic [5:0] ST_IDLE  = 6'b000001;
    localparam logic [5:0] ST_H32   = 6'b000010;
    localparam logic [5:0] ST_H64   = 6'b000100;
    localparam logic [5:0] ST_DATA  = 6'b001000;
    localparam logic [5:0] ST_EOFW  = 6'b010000;
    localparam logic [5:0] ST_DRAIN = 6'b100000;

    typedef enum logic [1:0] {
        TGT_NONE   = 2'd0,
        TGT_ADDR   = 2'd1,
        TGT_UNLOCK = 2'd2,
        TGT_COMPL  = 2'd3
    } hp_target_e;

    function automatic logic [31:0] bswap32(input logic [31:0] dw);
        return {dw[7:0], dw[15:8], dw[23:16], dw[31:24]};
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? 16'hFFFF : v + 16'd1;
    endfunction

endpackage

// File: rtl/tx_huge_pages_ctrl_hp_page_slot.sv
// One huge-page slot: address, qword count and ready status, with busy
// protection against overwriting a page the TX engine still owns.
module hp_page_slot (
    input  logic        trn_clk,
    input  logic        reset_n,
    input  logic        addr_wr,
    input  logic        unlock_wr,
    input  logic        free,
    input  logic [63:0] wr_data,
    output logic [63:0] addr,
    output logic [31:0] qwords,
    output logic        status,
    output logic        drop
);

    logic [63:0] addr_r;
    logic [31:0] qwords_r;
    logic        status_r;
    logic        busy_s;

    // A free pulse in the same cycle releases the page, so an unlock can land
    assign busy_s = status_r && !free;
    assign drop   = (addr_wr || unlock_wr) && busy_s;

    // Slot state update; unlock has priority over a coincident free
    always_ff @(posedge trn_clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_r   <= 64'd0;
            qwords_r <= 32'd0;
            status_r <= 1'b0;
        end else begin
            if (addr_wr && !busy_s) begin
                addr_r <= wr_data;
            end
            if (unlock_wr && !busy_s) begin
                qwords_r <= wr_data[31:0];
                status_r <= 1'b1;
            end else if (free) begin
                status_r <= 1'b0;
            end
        end
    end

    assign addr   = addr_r;
    assign qwords = qwords_r;
    assign status = status_r;

endmodule

// File: rtl/tx_huge_pages_ctrl.sv
// Decodes BAR-qualified MemWr32/64 TLPs into per-page address/unlock and a
// completion-buffer address. Optional drop counter: TX_HP_DROP_CNT_EN.
module tx_huge_pages_ctrl
    import tx_huge_pages_ctrl_pkg::*;
#(
    parameter int         NUM_PAGES = 2,
    parameter int         BAR_IDX   = 2,
    parameter logic [5:0] REG_BASE  = 6'h20
) (
    input  logic                      trn_clk,
    input  logic                      reset_n,
    input  logic [63:0]               trn_rd,
    input  logic [7:0]                trn_rrem_n,
    input  logic                      trn_rsof_n,
    input  logic                      trn_reof_n,
    input  logic                      trn_rsrc_rdy_n,
    input  logic                      trn_rsrc_dsc_n,
    input  logic                      trn_rdst_rdy_n,
    input  logic [6:0]                trn_rbar_hit_n,
    output logic [64*NUM_PAGES-1:0]   huge_page_addr,
    output logic [32*NUM_PAGES-1:0]   huge_page_qwords,
    output logic [NUM_PAGES-1:0]      huge_page_status,
    input  logic [NUM_PAGES-1:0]      huge_page_free,
    output logic [63:0]               completed_buffer_address,
    output logic [15:0]               drop_cnt
);

    logic [5:0]  state_r, state_nxt_s;
    logic [9:0]  len_r;
    logic        is64_r;
    logic [5:0]  idx_r, idx_s, rel_s;
    logic [31:0] dw0_r, dw0_s, dw1_r, dw1_s;
    logic [63:0] compl_r, value_s;
    logic        beat_s, sof_s, eof_s, dsc_s, commit_s, in_map_s;
    logic        len_ok_s, compl_wr_s;
    hp_target_e  tgt_s;
    logic [NUM_PAGES-1:0] page_sel_s, addr_wr_s, unlock_wr_s, slot_drop_s;

    assign beat_s = !trn_rsrc_rdy_n && !trn_rdst_rdy_n;
    assign sof_s  = beat_s && !trn_rsof_n;
    assign eof_s  = beat_s && !trn_reof_n;
    assign dsc_s  = beat_s && !trn_rsrc_dsc_n && (state_r != ST_IDLE);

    // Next-state logic; a SOF beat always restarts header decoding
    always_comb begin
        state_nxt_s = state_r;
        if (!beat_s) begin
            state_nxt_s = state_r;
        end else if (dsc_s) begin
            state_nxt_s = ST_IDLE;
        end else if (sof_s) begin
            if (eof_s) begin
                state_nxt_s = ST_IDLE;
            end else if (!trn_rbar_hit_n[BAR_IDX] && trn_rd[62:56] == FMT_MEM_WR32) begin
                state_nxt_s = ST_H32;
            end else if (!trn_rbar_hit_n[BAR_IDX] && trn_rd[62:56] == FMT_MEM_WR64) begin
                state_nxt_s = ST_H64;
            end else begin
                state_nxt_s = ST_DRAIN;
            end
        end else begin
            case (state_r)
                ST_IDLE:  state_nxt_s = ST_IDLE;
                ST_H32:   state_nxt_s = eof_s ? ST_IDLE : ((len_r == 10'd2) ? ST_DATA : ST_EOFW);
                ST_H64:   state_nxt_s = eof_s ? ST_IDLE : ST_DATA;
                ST_DATA:  state_nxt_s = eof_s ? ST_IDLE : ST_EOFW;
                ST_EOFW:  state_nxt_s = eof_s ? ST_IDLE : ST_EOFW;
                ST_DRAIN: state_nxt_s = eof_s ? ST_IDLE : ST_DRAIN;
                default:  state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // Index and data DWs as seen on the current beat, so a commit on the
    // same beat that carries the last payload uses it directly
    always_comb begin
        idx_s = idx_r;
        dw0_s = dw0_r;
        dw1_s = dw1_r;
        if (state_r == ST_H32) begin
            idx_s = trn_rd[39:34];
            dw0_s = trn_rd[31:0];
        end else if (state_r == ST_H64) begin
            idx_s = trn_rd[7:2];
        end else if (state_r == ST_DATA) begin
            if (is64_r) begin
                dw0_s = trn_rd[63:32];
                dw1_s = trn_rd[31:0];
            end else begin
                dw1_s = trn_rd[63:32];
            end
        end else begin
            idx_s = idx_r;
        end
    end

    assign commit_s = eof_s && !sof_s && !dsc_s &&
                      (state_r == ST_H32 || state_r == ST_DATA || state_r == ST_EOFW);
    assign rel_s    = idx_s - REG_BASE;
    assign in_map_s = (idx_s >= REG_BASE) && (rel_s < OFS_SPAN);
    assign value_s  = {bswap32(dw1_s), bswap32(dw0_s)};

    // Register-map decode of the committed write
    always_comb begin
        tgt_s      = TGT_NONE;
        page_sel_s = '0;
        for (int i = 0; i < NUM_PAGES; i++) begin
            if (rel_s == 6'(2 * i)) begin
                tgt_s         = TGT_ADDR;
                page_sel_s[i] = 1'b1;
            end else if (rel_s == OFS_UNLOCK + 6'(i)) begin
                tgt_s         = TGT_UNLOCK;
                page_sel_s[i] = 1'b1;
            end else begin
                page_sel_s[i] = 1'b0;
            end
        end
        if (rel_s == OFS_COMPL) begin
            tgt_s = TGT_COMPL;
        end else begin
            tgt_s = tgt_s;
        end
    end

    always_comb begin
        len_ok_s = 1'b0;
        case (tgt_s)
            TGT_ADDR:   len_ok_s = (len_r == 10'd2);
            TGT_COMPL:  len_ok_s = (len_r == 10'd2);
            TGT_UNLOCK: len_ok_s = (len_r == 10'd1);
            default:    len_ok_s = 1'b0;
        endcase
    end

    assign addr_wr_s   = (commit_s && in_map_s && len_ok_s && tgt_s == TGT_ADDR)   ? page_sel_s : '0;
    assign unlock_wr_s = (commit_s && in_map_s && len_ok_s && tgt_s == TGT_UNLOCK) ? page_sel_s : '0;
    assign compl_wr_s  = commit_s && in_map_s && len_ok_s && (tgt_s == TGT_COMPL);

    // FSM state register
    always_ff @(posedge trn_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Header/payload shadow registers and completion address
    always_ff @(posedge trn_clk or negedge reset_n) begin
        if (!reset_n) begin
            len_r   <= 10'd0;
            is64_r  <= 1'b0;
            idx_r   <= 6'd0;
            dw0_r   <= 32'd0;
            dw1_r   <= 32'd0;
            compl_r <= 64'd0;
        end else begin
            if (sof_s) begin
                len_r  <= trn_rd[41:32];
                is64_r <= (trn_rd[62:56] == FMT_MEM_WR64);
            end
            if (beat_s) begin
                idx_r <= idx_s;
                dw0_r <= dw0_s;
                dw1_r <= dw1_s;
            end
            if (compl_wr_s) begin
                compl_r <= value_s;
            end
        end
    end

    assign completed_buffer_address = compl_r;

    genvar g;
    generate
        for (g = 0; g < NUM_PAGES; g++) begin : g_slot
            hp_page_slot u_slot (
                .trn_clk   (trn_clk),
                .reset_n   (reset_n),
                .addr_wr   (addr_wr_s[g]),
                .unlock_wr (unlock_wr_s[g]),
                .free      (huge_page_free[g]),
                .wr_data   (value_s),
                .addr      (huge_page_addr[64*g +: 64]),
                .qwords    (huge_page_qwords[32*g +: 32]),
                .status    (huge_page_status[g]),
                .drop      (slot_drop_s[g])
            );
        end
    endgenerate

`ifdef TX_HP_DROP_CNT_EN
    logic        drop_s;
    logic [15:0] drop_cnt_r;

    assign drop_s = commit_s && in_map_s && (!len_ok_s || (|slot_drop_s));

    // Saturating count of rejected commits
    always_ff @(posedge trn_clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt_r <= 16'd0;
        end else if (drop_s) begin
            drop_cnt_r <= sat_inc16(drop_cnt_r);
        end
    end

    assign drop_cnt = drop_cnt_r;
`else
    assign drop_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_tx_huge_pages_ctrl.sv
// Directed self-checking bench for tx_huge_pages_ctrl (NUM_PAGES=2, BAR2, base 0x20).
module tb_tx_huge_pages_ctrl;

    logic          trn_clk = 1'b0;
    logic          reset_n;
    logic [63:0]   trn_rd;
    logic [7:0]    trn_rrem_n;
    logic          trn_rsof_n, trn_reof_n, trn_rsrc_rdy_n, trn_rsrc_dsc_n, trn_rdst_rdy_n;
    logic [6:0]    trn_rbar_hit_n;
    logic [127:0]  huge_page_addr;
    logic [63:0]   huge_page_qwords;
    logic [1:0]    huge_page_status;
    logic [1:0]    huge_page_free;
    logic [63:0]   completed_buffer_address;
    logic [15:0]   drop_cnt;

    int            total = 0;
    int            bad = 0;
    logic [15:0]   exp_drop;

`ifdef TX_HP_DROP_CNT_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    localparam logic [6:0] BAR2 = 7'b1111011;
    localparam logic [6:0] BAR0 = 7'b1111110;

    tx_huge_pages_ctrl #(.NUM_PAGES(2), .BAR_IDX(2), .REG_BASE(6'h20)) dut (
        .trn_clk                  (trn_clk),
        .reset_n                  (reset_n),
        .trn_rd                   (trn_rd),
        .trn_rrem_n               (trn_rrem_n),
        .trn_rsof_n               (trn_rsof_n),
        .trn_reof_n               (trn_reof_n),
        .trn_rsrc_rdy_n           (trn_rsrc_rdy_n),
        .trn_rsrc_dsc_n           (trn_rsrc_dsc_n),
        .trn_rdst_rdy_n           (trn_rdst_rdy_n),
        .trn_rbar_hit_n           (trn_rbar_hit_n),
        .huge_page_addr           (huge_page_addr),
        .huge_page_qwords         (huge_page_qwords),
        .huge_page_status         (huge_page_status),
        .huge_page_free           (huge_page_free),
        .completed_buffer_address (completed_buffer_address),
        .drop_cnt                 (drop_cnt)
    );

    always #5 trn_clk = ~trn_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic sof, input logic eof, input logic dsc,
                        input logic [63:0] d, input logic [6:0] bar);
        trn_rsrc_rdy_n = 1'b0;
        trn_rsof_n     = ~sof;
        trn_reof_n     = ~eof;
        trn_rsrc_dsc_n = ~dsc;
        trn_rd         = d;
        trn_rbar_hit_n = bar;
        @(posedge trn_clk);
        #1;
        trn_rsrc_rdy_n = 1'b1;
        trn_rsof_n     = 1'b1;
        trn_reof_n     = 1'b1;
        trn_rsrc_dsc_n = 1'b1;
    endtask

    function automatic logic [63:0] hdr(input logic [6:0] fmt, input logic [9:0] len);
        return {1'b0, fmt, 14'd0, len, 32'h0000_00FF};
    endfunction

    task automatic wr32(input logic [5:0] idx, input logic [9:0] len,
                        input logic [31:0] d0, input logic [31:0] d1, input logic [6:0] bar);
        beat(1'b1, 1'b0, 1'b0, hdr(7'h40, len), bar);
        if (len == 10'd1) begin
            beat(1'b0, 1'b1, 1'b0, {24'd0, idx, 2'b00, d0}, bar);
        end else begin
            beat(1'b0, 1'b0, 1'b0, {24'd0, idx, 2'b00, d0}, bar);
            beat(1'b0, 1'b1, 1'b0, {d1, 32'd0}, bar);
        end
    endtask

    task automatic wr64(input logic [5:0] idx, input logic [9:0] len,
                        input logic [31:0] d0, input logic [31:0] d1, input logic [6:0] bar);
        beat(1'b1, 1'b0, 1'b0, hdr(7'h60, len), bar);
        beat(1'b0, 1'b0, 1'b0, {32'd0, 24'd0, idx, 2'b00}, bar);
        beat(1'b0, 1'b1, 1'b0, {d0, d1}, bar);
    endtask

    initial begin
        reset_n        = 1'b0;
        trn_rd         = 64'd0;
        trn_rrem_n     = 8'h00;
        trn_rsof_n     = 1'b1;
        trn_reof_n     = 1'b1;
        trn_rsrc_rdy_n = 1'b1;
        trn_rsrc_dsc_n = 1'b1;
        trn_rdst_rdy_n = 1'b0;
        trn_rbar_hit_n = 7'h7F;
        huge_page_free = 2'b00;
        exp_drop       = 16'd0;
        repeat (2) @(posedge trn_clk);
        #1;
        chk("rst_addr",   huge_page_addr[63:0], 64'd0);
        chk("rst_addr1",  huge_page_addr[127:64], 64'd0);
        chk("rst_qwords", huge_page_qwords, 64'd0);
        chk("rst_status", {62'd0, huge_page_status}, 64'd0);
        chk("rst_compl",  completed_buffer_address, 64'd0);
        chk("rst_drop",   {48'd0, drop_cnt}, 64'd0);
        reset_n = 1'b1;
        @(posedge trn_clk);
        #1;

        // Page 0 address via MemWr32
        wr32(6'h20, 10'd2, 32'h78563412, 32'hF0DEBC9A, BAR2);
        chk("addr0_wr32", huge_page_addr[63:0], 64'h9ABCDEF0_12345678);
        chk("addr1_untouched", huge_page_addr[127:64], 64'd0);

        // Page 1 unlock via MemWr64, then free
        wr64(6'h29, 10'd1, 32'h00100000, 32'h0, BAR2);
        chk("qw1_unlock", {32'd0, huge_page_qwords[63:32]}, 64'h0000_1000);
        chk("status_p1",  {62'd0, huge_page_status}, 64'd2);
        huge_page_free = 2'b10;
        @(posedge trn_clk);
        #1;
        huge_page_free = 2'b00;
        chk("status_freed", {62'd0, huge_page_status}, 64'd0);
        chk("qw1_kept",     {32'd0, huge_page_qwords[63:32]}, 64'h0000_1000);

        // Page 0 unlock, then a rejected second unlock and address write
        wr32(6'h28, 10'd1, 32'h00020000, 32'h0, BAR2);
        chk("qw0_unlock", {32'd0, huge_page_qwords[31:0]}, 64'h0000_0200);
        chk("status_p0",  {62'd0, huge_page_status}, 64'd1);
        wr32(6'h28, 10'd1, 32'h00030000, 32'h0, BAR2);
        exp_drop = DROP_EN ? exp_drop + 16'd1 : 16'd0;
        chk("qw0_busy",   {32'd0, huge_page_qwords[31:0]}, 64'h0000_0200);
        chk("drop_busy",  {48'd0, drop_cnt}, {48'd0, exp_drop});
        wr32(6'h20, 10'd2, 32'h11111111, 32'h22222222, BAR2);
        exp_drop = DROP_EN ? exp_drop + 16'd1 : 16'd0;
        chk("addr0_busy", huge_page_addr[63:0], 64'h9ABCDEF0_12345678);
        chk("drop_busy_addr", {48'd0, drop_cnt}, {48'd0, exp_drop});

        // Unlock coinciding with free on the same page is accepted
        beat(1'b1, 1'b0, 1'b0, hdr(7'h40, 10'd1), BAR2);
        huge_page_free = 2'b01;
        beat(1'b0, 1'b1, 1'b0, {24'd0, 6'h28, 2'b00, 32'h00030000}, BAR2);
        huge_page_free = 2'b00;
        chk("qw0_free_unlock", {32'd0, huge_page_qwords[31:0]}, 64'h0000_0300);
        chk("status_free_unlock", {62'd0, huge_page_status}, 64'd1);
        chk("drop_free_unlock", {48'd0, drop_cnt}, {48'd0, exp_drop});

        // Discontinued TLP, then a normal one back-to-back
        beat(1'b1, 1'b0, 1'b0, hdr(7'h40, 10'd2), BAR2);
        beat(1'b0, 1'b0, 1'b1, {24'd0, 6'h22, 2'b00, 32'hAAAAAAAA}, BAR2);
        wr32(6'h22, 10'd2, 32'h44332211, 32'h88776655, BAR2);
        chk("addr1_after_dsc", huge_page_addr[127:64], 64'h55667788_11223344);
        chk("drop_dsc", {48'd0, drop_cnt}, {48'd0, exp_drop});

        // Completion address: bad length, wrong BAR, then good
        wr32(6'h2C, 10'd1, 32'h0DF0ADDE, 32'h0, BAR2);
        exp_drop = DROP_EN ? exp_drop + 16'd1 : 16'd0;
        chk("compl_badlen", completed_buffer_address, 64'd0);
        chk("drop_badlen", {48'd0, drop_cnt}, {48'd0, exp_drop});
        wr32(6'h2C, 10'd2, 32'h0DF0ADDE, 32'hBEBAFECA, BAR0);
        chk("compl_bar0", completed_buffer_address, 64'd0);
        chk("drop_bar0", {48'd0, drop_cnt}, {48'd0, exp_drop});
        wr64(6'h2C, 10'd2, 32'h0DF0ADDE, 32'hBEBAFECA, BAR2);
        chk("compl_wr64", completed_buffer_address, 64'hCAFEBABE_DEADF00D);

        // Odd DW inside the map is unmapped
        wr32(6'h21, 10'd2, 32'h01010101, 32'h02020202, BAR2);
        exp_drop = DROP_EN ? exp_drop + 16'd1 : 16'd0;
        chk("addr0_unmapped", huge_page_addr[63:0], 64'h9ABCDEF0_12345678);
        chk("drop_unmapped", {48'd0, drop_cnt}, {48'd0, exp_drop});

        // Asynchronous reset in the middle of a TLP
        beat(1'b1, 1'b0, 1'b0, hdr(7'h40, 10'd2), BAR2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_addr",   huge_page_addr, 64'd0);
        chk("arst_addr1",  huge_page_addr[127:64], 64'd0);
        chk("arst_qwords", huge_page_qwords, 64'd0);
        chk("arst_status", {62'd0, huge_page_status}, 64'd0);
        chk("arst_compl",  completed_buffer_address, 64'd0);
        chk("arst_drop",   {48'd0, drop_cnt}, 64'd0);
        #3;
        reset_n = 1'b1;
        @(posedge trn_clk);
        #1;
        wr32(6'h20, 10'd2, 32'h04030201, 32'h08070605, BAR2);
        chk("addr0_post_rst", huge_page_addr[63:0], 64'h05060708_01020304);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
